// File: rtl/mix_decimator.sv
// Decimating boxcar filter for a signed 32-bit mixer product stream.
// Sums DECIM beats (or fewer when tlast cuts a window short) and emits the sum shifted right by LOG2_DECIM.
module mix_decimator #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int LOG2_DECIM             = 4
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic                                s00_axis_tvalid,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                                s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    output logic                                s00_axis_tready,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

    localparam int ACC_W = C_S00_AXIS_TDATA_WIDTH + LOG2_DECIM;

    if (C_S00_AXIS_TDATA_WIDTH != 32 || C_M00_AXIS_TDATA_WIDTH != 32) begin : g_badWidth
        $error("mix_decimator: only 32-bit stream widths are supported");
    end
    if (LOG2_DECIM < 1 || LOG2_DECIM > 8) begin : g_badDecim
        $error("mix_decimator: LOG2_DECIM must be in 1..8");
    end

    logic signed [ACC_W-1:0]                  r_acc;
    logic        [LOG2_DECIM-1:0]             r_count;
    logic                                     r_mValid;
    logic                                     r_mLast;
    logic        [C_M00_AXIS_TDATA_WIDTH-1:0] r_mData;

    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_sReady;
    logic                    w_accept;
    logic                    w_close;
    logic                    w_unused;

    // Guard bits in the accumulator make a full window of full-scale samples fit without overflow.
    assign w_ext    = {{LOG2_DECIM{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1]}}, s00_axis_tdata};
    assign w_sum    = r_acc + w_ext;
    assign w_sReady = !r_mValid || m00_axis_tready;
    assign w_accept = s00_axis_tvalid && w_sReady;
    assign w_close  = w_accept && (s00_axis_tlast || (&r_count));
    assign w_unused = ^{s00_axis_tstrb, w_sum[LOG2_DECIM-1:0]};

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
            r_mData  <= '0;
        end else begin
            if (w_close) begin
                // Taking the upper slice is an arithmetic shift with floor rounding.
                r_mData  <= w_sum[LOG2_DECIM +: C_M00_AXIS_TDATA_WIDTH];
                r_mValid <= 1'b1;
                r_mLast  <= s00_axis_tlast;
                r_acc    <= '0;
                r_count  <= '0;
            end else begin
                if (w_accept) begin
                    r_acc   <= w_sum;
                    r_count <= r_count + 1'b1;
                end
                if (r_mValid && m00_axis_tready) begin
                    r_mValid <= 1'b0;
                end
            end
        end
    end

    assign s00_axis_tready = w_sReady;
    assign m00_axis_tvalid = r_mValid;
    assign m00_axis_tdata  = r_mData;
    assign m00_axis_tlast  = r_mLast;
    assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_mix_decimator.sv
// Directed self-checking bench for mix_decimator with DECIM = 4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mix_decimator;

    logic        clk;
    logic        rst_n;
    logic        sValid;
    logic [31:0] sData;
    logic        sLast;
    logic [3:0]  sStrb;
    logic        sReady;
    logic        mReady;
    logic        mValid;
    logic [31:0] mData;
    logic        mLast;
    logic [3:0]  mStrb;

    int assertCount = 0;
    int failCount   = 0;

    mix_decimator #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .LOG2_DECIM(2)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid (sValid),
        .s00_axis_tdata  (sData),
        .s00_axis_tlast  (sLast),
        .s00_axis_tstrb  (sStrb),
        .s00_axis_tready (sReady),
        .m00_axis_tready (mReady),
        .m00_axis_tvalid (mValid),
        .m00_axis_tdata  (mData),
        .m00_axis_tlast  (mLast),
        .m00_axis_tstrb  (mStrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One beat presented for exactly one clock edge; returns 1 unit after that edge.
    task automatic applyStimulus(input logic [31:0] d, input logic l);
        sValid = 1'b1;
        sData  = d;
        sLast  = l;
        @(posedge clk);
        #1;
        sValid = 1'b0;
        sLast  = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        sValid = 1'b0;
        sData  = '0;
        sLast  = 1'b0;
        sStrb  = 4'h0;
        mReady = 1'b1;

        idleCycle();
        idleCycle();
        checkOutput("rst_valid", {31'd0, mValid}, 32'd0);
        checkOutput("rst_data", mData, 32'd0);
        checkOutput("rst_last", {31'd0, mLast}, 32'd0);
        checkOutput("rst_sready", {31'd0, sReady}, 32'd1);
        checkOutput("strb", {28'd0, mStrb}, 32'h0000_000F);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_sready", {31'd0, sReady}, 32'd1);

        applyStimulus(32'd100, 1'b0);
        applyStimulus(32'd200, 1'b0);
        applyStimulus(32'd300, 1'b0);
        checkOutput("avg_pre_valid", {31'd0, mValid}, 32'd0);
        applyStimulus(32'd400, 1'b0);
        checkOutput("avg_valid", {31'd0, mValid}, 32'd1);
        checkOutput("avg_data", mData, 32'd250);
        checkOutput("avg_last", {31'd0, mLast}, 32'd0);
        idleCycle();
        checkOutput("avg_drop", {31'd0, mValid}, 32'd0);

        applyStimulus(32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'hFFFF_FFFE, 1'b0);
        checkOutput("neg_valid", {31'd0, mValid}, 32'd1);
        checkOutput("neg_data", mData, 32'hFFFF_FFFE);

        applyStimulus(32'd8, 1'b0);
        checkOutput("part_mid_valid", {31'd0, mValid}, 32'd0);
        applyStimulus(32'd8, 1'b1);
        checkOutput("part_valid", {31'd0, mValid}, 32'd1);
        checkOutput("part_data", mData, 32'd4);
        checkOutput("part_last", {31'd0, mLast}, 32'd1);
        applyStimulus(32'd4, 1'b0);
        applyStimulus(32'd4, 1'b0);
        applyStimulus(32'd4, 1'b0);
        applyStimulus(32'd4, 1'b0);
        checkOutput("after_part_data", mData, 32'd4);
        checkOutput("after_part_last", {31'd0, mLast}, 32'd0);

        // Single-beat windows closed by tlast on consecutive edges.
        applyStimulus(32'd8, 1'b1);
        checkOutput("b2b_first", mData, 32'd2);
        applyStimulus(32'd12, 1'b1);
        checkOutput("b2b_valid", {31'd0, mValid}, 32'd1);
        checkOutput("b2b_second", mData, 32'd3);
        idleCycle();

        applyStimulus(32'd1, 1'b0);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'd3, 1'b0);
        applyStimulus(32'd6, 1'b0);
        checkOutput("bp_data", mData, 32'd3);
        mReady = 1'b0;
        sValid = 1'b1;
        sData  = 32'd40;
        #1;
        checkOutput("bp_sready", {31'd0, sReady}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            idleCycle();
            checkOutput("bp_hold_valid", {31'd0, mValid}, 32'd1);
            checkOutput("bp_hold_data", mData, 32'd3);
            checkOutput("bp_hold_sready", {31'd0, sReady}, 32'd0);
        end
        mReady = 1'b1;
        #1;
        checkOutput("bp_release_sready", {31'd0, sReady}, 32'd1);
        idleCycle();
        sValid = 1'b0;
        checkOutput("bp_release_drop", {31'd0, mValid}, 32'd0);
        applyStimulus(32'd40, 1'b0);
        applyStimulus(32'd40, 1'b0);
        checkOutput("bp_resume_pending", {31'd0, mValid}, 32'd0);
        applyStimulus(32'd40, 1'b0);
        checkOutput("bp_resume_valid", {31'd0, mValid}, 32'd1);
        checkOutput("bp_resume_data", mData, 32'd40);
        idleCycle();

        applyStimulus(32'd1000, 1'b0);
        applyStimulus(32'd1000, 1'b0);
        applyStimulus(32'd1000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, mValid}, 32'd0);
        checkOutput("midrst_data", mData, 32'd0);
        #2;
        rst_n = 1'b1;
        idleCycle();
        applyStimulus(32'd4, 1'b0);
        checkOutput("midrst_no_out", {31'd0, mValid}, 32'd0);
        applyStimulus(32'd8, 1'b0);
        applyStimulus(32'd12, 1'b0);
        checkOutput("midrst_pending", {31'd0, mValid}, 32'd0);
        applyStimulus(32'd16, 1'b0);
        checkOutput("midrst_valid2", {31'd0, mValid}, 32'd1);
        checkOutput("midrst_data2", mData, 32'd10);

        for (int i = 0; i < 4; i++) applyStimulus(32'h7FFF_FFFF, 1'b0);
        checkOutput("fs_pos", mData, 32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) applyStimulus(32'h8000_0000, 1'b0);
        checkOutput("fs_neg", mData, 32'h8000_0000);
        checkOutput("fs_neg_valid", {31'd0, mValid}, 32'd1);
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
